// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings for the uart_tx arbiter slice: FSM states and grant index width.
package uart_tx_arbiter_pkg;

  // Width of grant_id and of the internal grant/pointer registers.
  // It stays at 2 for every supported requester count (2..4).
  localparam int GRANT_ID_W = 2;

  // Width of the per-grant byte counter.
  localparam int BURST_CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Circular priority encoder: picks the first set request at or after ptr, wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [IDX_W:0] NUM_REQ_X = (IDX_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [IDX_W:0]       w_sum;

  // Duplicating the request vector lets a plain right shift act as a rotation by ptr.
  assign w_req2 = {req, req};
  assign w_rot  = NUM_REQ'(w_req2 >> ptr);
  assign any    = |req;

  // Find the lowest set bit of the rotated vector and map its offset back to an absolute index.
  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, ptr} + (IDX_W+1)'(k);
        if (w_sum >= NUM_REQ_X) begin
          w_sum = w_sum - NUM_REQ_X;
        end
        idx = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx byte port among NUM_REQ requesters.
// A grant is held until the granted requester sends a byte marked last or MAX_BURST bytes pass.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic [GRANT_ID_W-1:0]         grant_id
);

  localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);
  localparam logic [GRANT_ID_W-1:0]  LAST_IDX    = GRANT_ID_W'(NUM_REQ - 1);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [GRANT_ID_W-1:0]   r_grant;
  logic [GRANT_ID_W-1:0]   w_grant_next;
  logic [GRANT_ID_W-1:0]   r_rr_ptr;
  logic [GRANT_ID_W-1:0]   w_rr_ptr_next;
  logic [BURST_CNT_W-1:0]  r_burst_cnt;
  logic [BURST_CNT_W-1:0]  w_burst_cnt_next;

  logic                    w_any;
  logic [GRANT_ID_W-1:0]   w_pick_idx;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_active;
  logic                    w_xfer;
  logic                    w_release;
  logic                    w_tx_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GRANT_ID_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .any (w_any),
    .idx (w_pick_idx)
  );

  // Route the granted requester's lane onto the shared select signals.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == GRANT_ID_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset is gated in so an asserted reset blocks any handshake in that same cycle.
  assign w_active   = reset && (r_state == ST_GRANT);
  assign w_xfer     = w_active && w_sel_valid && tx_ready;
  assign w_release  = w_xfer && (w_sel_last || ((r_burst_cnt + 8'd1) == BURST_LIMIT));
  assign w_tx_valid = w_active && w_sel_valid;

  assign tx_valid = w_tx_valid;
  assign tx_data  = w_tx_valid ? w_sel_data : '0;
  assign busy     = w_active;
  assign grant_id = w_active ? r_grant : '0;

  // Only the grantee sees tx_ready; everyone else is held off.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_active && (r_grant == GRANT_ID_W'(i)) && tx_ready;
    end
  end

  // Next-state logic: arbitrate in IDLE, count bytes and watch for release in GRANT.
  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_rr_ptr_next    = r_rr_ptr;
    w_burst_cnt_next = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_next     = ST_GRANT;
          w_grant_next     = w_pick_idx;
          w_burst_cnt_next = '0;
        end
      end
      ST_GRANT: begin
        if (w_xfer) begin
          w_burst_cnt_next = r_burst_cnt + 8'd1;
          if (w_release) begin
            w_state_next  = ST_IDLE;
            w_rr_ptr_next = (r_grant == LAST_IDX) ? '0 : r_grant + GRANT_ID_W'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and arbitration registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_burst_cnt <= w_burst_cnt_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with two requesters and MAX_BURST=4.
// Each cycle drives a stimulus vector just after the rising edge and checks the
// combinational outputs on the falling edge against a hand-computed expectation.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic       rstn;
    logic [1:0] valid;
    logic [1:0] last;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       txReady;
  } stim_t;

  // Observed/expected packing: {tx_valid, tx_data, req_ready, busy, grant_id}
  typedef struct packed {
    logic       txValid;
    logic [7:0] txData;
    logic [1:0] ready;
    logic       busy;
    logic [1:0] gid;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic [1:0]  grant_id;

  int nCompared   = 0;
  int nMismatched = 0;

  uart_tx_arbiter #(
    .NUM_REQ    (2),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic stim_t mkS(input logic rstn, input logic [1:0] v, input logic [1:0] l,
                                input logic [7:0] a, input logic [7:0] b, input logic r);
    mkS = {rstn, v, l, a, b, r};
  endfunction

  function automatic exp_t mkE(input logic tv, input logic [7:0] td, input logic [1:0] rdy,
                               input logic bsy, input logic [1:0] gid);
    mkE = {tv, td, rdy, bsy, gid};
  endfunction

  task automatic applyStimulus(input stim_t s);
    reset     = s.rstn;
    req_valid = s.valid;
    req_last  = s.last;
    req_data  = {s.d1, s.d0};
    tx_ready  = s.txReady;
  endtask

  // Reset held low for three cycles with every requester asking: nothing may leak out.
  task automatic test_reset();
    exp_t obs;
    exp_t want;
    want = mkE(1'b0, 8'h00, 2'b00, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkS(1'b0, 2'b11, 2'b00, 8'h5A, 8'hA5, 1'b1));
      @(negedge clk);
      obs = {tx_valid, tx_data, req_ready, busy, grant_id};
      nCompared++;
      if (obs !== want) begin
        nMismatched++;
        $display("[TB] FAIL reset_hold c%0d: got %h want %h", i, obs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  // One three-byte message from requester 0.
  task automatic test_single();
    stim_t s[5];
    exp_t  e[5];
    exp_t  obs;
    s[0] = mkS(1, 2'b01, 2'b00, 8'h41, 8'h00, 1); e[0] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[1] = mkS(1, 2'b01, 2'b00, 8'h41, 8'h00, 1); e[1] = mkE(1, 8'h41, 2'b01, 1, 2'd0);
    s[2] = mkS(1, 2'b01, 2'b00, 8'h42, 8'h00, 1); e[2] = mkE(1, 8'h42, 2'b01, 1, 2'd0);
    s[3] = mkS(1, 2'b01, 2'b01, 8'h43, 8'h00, 1); e[3] = mkE(1, 8'h43, 2'b01, 1, 2'd0);
    s[4] = mkS(1, 2'b00, 2'b00, 8'h00, 8'h00, 1); e[4] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(s[i]);
      @(negedge clk);
      obs = {tx_valid, tx_data, req_ready, busy, grant_id};
      nCompared++;
      if (obs !== e[i]) begin
        nMismatched++;
        $display("[TB] FAIL single c%0d: got %h want %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Requester 1 message under tx_ready 1,0,0,1 while requester 0 also waits.
  task automatic test_backpressure();
    stim_t s[6];
    exp_t  e[6];
    exp_t  obs;
    s[0] = mkS(1, 2'b10, 2'b00, 8'h00, 8'h10, 1); e[0] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[1] = mkS(1, 2'b11, 2'b00, 8'h55, 8'h10, 1); e[1] = mkE(1, 8'h10, 2'b10, 1, 2'd1);
    s[2] = mkS(1, 2'b11, 2'b10, 8'h55, 8'h11, 0); e[2] = mkE(1, 8'h11, 2'b00, 1, 2'd1);
    s[3] = mkS(1, 2'b11, 2'b10, 8'h55, 8'h11, 0); e[3] = mkE(1, 8'h11, 2'b00, 1, 2'd1);
    s[4] = mkS(1, 2'b11, 2'b10, 8'h55, 8'h11, 1); e[4] = mkE(1, 8'h11, 2'b10, 1, 2'd1);
    s[5] = mkS(1, 2'b00, 2'b00, 8'h00, 8'h00, 1); e[5] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(s[i]);
      @(negedge clk);
      obs = {tx_valid, tx_data, req_ready, busy, grant_id};
      nCompared++;
      if (obs !== e[i]) begin
        nMismatched++;
        $display("[TB] FAIL backpressure c%0d: got %h want %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Both requesters continuously valid with two-byte messages: A B A B with one bubble each.
  task automatic test_round_robin();
    stim_t s[13];
    exp_t  e[13];
    exp_t  obs;
    s[0]  = mkS(1, 2'b11, 2'b00, 8'hA0, 8'hB0, 1); e[0]  = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[1]  = mkS(1, 2'b11, 2'b00, 8'hA0, 8'hB0, 1); e[1]  = mkE(1, 8'hA0, 2'b01, 1, 2'd0);
    s[2]  = mkS(1, 2'b11, 2'b01, 8'hA1, 8'hB0, 1); e[2]  = mkE(1, 8'hA1, 2'b01, 1, 2'd0);
    s[3]  = mkS(1, 2'b11, 2'b00, 8'hA0, 8'hB0, 1); e[3]  = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[4]  = mkS(1, 2'b11, 2'b00, 8'hA0, 8'hB0, 1); e[4]  = mkE(1, 8'hB0, 2'b10, 1, 2'd1);
    s[5]  = mkS(1, 2'b11, 2'b10, 8'hA0, 8'hB1, 1); e[5]  = mkE(1, 8'hB1, 2'b10, 1, 2'd1);
    s[6]  = mkS(1, 2'b11, 2'b00, 8'hA0, 8'hB0, 1); e[6]  = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[7]  = mkS(1, 2'b11, 2'b00, 8'hA0, 8'hB0, 1); e[7]  = mkE(1, 8'hA0, 2'b01, 1, 2'd0);
    s[8]  = mkS(1, 2'b11, 2'b01, 8'hA1, 8'hB0, 1); e[8]  = mkE(1, 8'hA1, 2'b01, 1, 2'd0);
    s[9]  = mkS(1, 2'b10, 2'b00, 8'h00, 8'hB0, 1); e[9]  = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[10] = mkS(1, 2'b10, 2'b00, 8'h00, 8'hB0, 1); e[10] = mkE(1, 8'hB0, 2'b10, 1, 2'd1);
    s[11] = mkS(1, 2'b10, 2'b10, 8'h00, 8'hB1, 1); e[11] = mkE(1, 8'hB1, 2'b10, 1, 2'd1);
    s[12] = mkS(1, 2'b00, 2'b00, 8'h00, 8'h00, 1); e[12] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(s[i]);
      @(negedge clk);
      obs = {tx_valid, tx_data, req_ready, busy, grant_id};
      nCompared++;
      if (obs !== e[i]) begin
        nMismatched++;
        $display("[TB] FAIL round_robin c%0d: got %h want %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Requester 0 streams without last; grant rotates after 4 bytes. Also covers a stalled
  // grantee holding the grant, and last coinciding with the burst limit (single release).
  task automatic test_forced_rotation();
    stim_t s[21];
    exp_t  e[21];
    exp_t  obs;
    s[0]  = mkS(1, 2'b11, 2'b10, 8'h00, 8'hB5, 1); e[0]  = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[1]  = mkS(1, 2'b11, 2'b10, 8'h00, 8'hB5, 1); e[1]  = mkE(1, 8'h00, 2'b01, 1, 2'd0);
    s[2]  = mkS(1, 2'b11, 2'b10, 8'h01, 8'hB5, 1); e[2]  = mkE(1, 8'h01, 2'b01, 1, 2'd0);
    s[3]  = mkS(1, 2'b11, 2'b10, 8'h02, 8'hB5, 1); e[3]  = mkE(1, 8'h02, 2'b01, 1, 2'd0);
    s[4]  = mkS(1, 2'b11, 2'b10, 8'h03, 8'hB5, 1); e[4]  = mkE(1, 8'h03, 2'b01, 1, 2'd0);
    s[5]  = mkS(1, 2'b11, 2'b10, 8'h04, 8'hB5, 1); e[5]  = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[6]  = mkS(1, 2'b11, 2'b10, 8'h04, 8'hB5, 1); e[6]  = mkE(1, 8'hB5, 2'b10, 1, 2'd1);
    s[7]  = mkS(1, 2'b01, 2'b00, 8'h04, 8'h00, 1); e[7]  = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[8]  = mkS(1, 2'b01, 2'b00, 8'h04, 8'h00, 1); e[8]  = mkE(1, 8'h04, 2'b01, 1, 2'd0);
    s[9]  = mkS(1, 2'b01, 2'b00, 8'h05, 8'h00, 1); e[9]  = mkE(1, 8'h05, 2'b01, 1, 2'd0);
    s[10] = mkS(1, 2'b10, 2'b10, 8'h06, 8'hB5, 1); e[10] = mkE(0, 8'h00, 2'b01, 1, 2'd0);
    s[11] = mkS(1, 2'b10, 2'b10, 8'h06, 8'hB5, 1); e[11] = mkE(0, 8'h00, 2'b01, 1, 2'd0);
    s[12] = mkS(1, 2'b11, 2'b10, 8'h06, 8'hB5, 1); e[12] = mkE(1, 8'h06, 2'b01, 1, 2'd0);
    s[13] = mkS(1, 2'b11, 2'b11, 8'h07, 8'hB5, 1); e[13] = mkE(1, 8'h07, 2'b01, 1, 2'd0);
    s[14] = mkS(1, 2'b11, 2'b10, 8'h08, 8'hB5, 1); e[14] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[15] = mkS(1, 2'b11, 2'b10, 8'h08, 8'hB5, 1); e[15] = mkE(1, 8'hB5, 2'b10, 1, 2'd1);
    s[16] = mkS(1, 2'b01, 2'b00, 8'h08, 8'h00, 1); e[16] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[17] = mkS(1, 2'b01, 2'b01, 8'h08, 8'h00, 1); e[17] = mkE(1, 8'h08, 2'b01, 1, 2'd0);
    s[18] = mkS(1, 2'b01, 2'b01, 8'h09, 8'h00, 1); e[18] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[19] = mkS(1, 2'b01, 2'b01, 8'h09, 8'h00, 1); e[19] = mkE(1, 8'h09, 2'b01, 1, 2'd0);
    s[20] = mkS(1, 2'b00, 2'b00, 8'h00, 8'h00, 1); e[20] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    for (int i = 0; i < 21; i++) begin
      applyStimulus(s[i]);
      @(negedge clk);
      obs = {tx_valid, tx_data, req_ready, busy, grant_id};
      nCompared++;
      if (obs !== e[i]) begin
        nMismatched++;
        $display("[TB] FAIL forced_rotation c%0d: got %h want %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset lands mid-message on requester 1 (pointer was 1); afterwards requester 0 wins first.
  task automatic test_reset_mid();
    stim_t s[9];
    exp_t  e[9];
    exp_t  obs;
    s[0] = mkS(1, 2'b10, 2'b00, 8'h00, 8'hC0, 1); e[0] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[1] = mkS(1, 2'b10, 2'b00, 8'h00, 8'hC0, 1); e[1] = mkE(1, 8'hC0, 2'b10, 1, 2'd1);
    s[2] = mkS(1, 2'b10, 2'b00, 8'h00, 8'hC1, 1); e[2] = mkE(1, 8'hC1, 2'b10, 1, 2'd1);
    s[3] = mkS(0, 2'b11, 2'b00, 8'h50, 8'hC2, 1); e[3] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[4] = mkS(1, 2'b11, 2'b00, 8'h50, 8'hC2, 1); e[4] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[5] = mkS(1, 2'b11, 2'b01, 8'h50, 8'hC2, 1); e[5] = mkE(1, 8'h50, 2'b01, 1, 2'd0);
    s[6] = mkS(1, 2'b10, 2'b00, 8'h00, 8'hC2, 1); e[6] = mkE(0, 8'h00, 2'b00, 0, 2'd0);
    s[7] = mkS(1, 2'b10, 2'b00, 8'h00, 8'hC2, 1); e[7] = mkE(1, 8'hC2, 2'b10, 1, 2'd1);
    s[8] = mkS(1, 2'b00, 2'b00, 8'h00, 8'hC3, 1); e[8] = mkE(0, 8'h00, 2'b10, 1, 2'd1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(s[i]);
      @(negedge clk);
      obs = {tx_valid, tx_data, req_ready, busy, grant_id};
      nCompared++;
      if (obs !== e[i]) begin
        nMismatched++;
        $display("[TB] FAIL reset_mid c%0d: got %h want %h", i, obs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Scenario sequence; order matters because each scenario starts from the
  // round-robin pointer left by the previous one.
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_forced_rotation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx byte transmitter between NUM_REQ byte-stream requesters, such as a status reporter and a debug dump.
- Arbitration is round-robin at message granularity, so a message marked by last is never interleaved with another requester's bytes.
- Sits between the requesters and the uart_tx byte interface inside the tile top level.
- Also forces rotation after MAX_BURST bytes, so an unterminated stream cannot starve the other requesters.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- DATA_WIDTH, 8, bits per byte lane.
- MAX_BURST, 16, maximum bytes accepted per grant before forced release; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester byte; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the final byte of a message; qualified by valid.
- req_ready  output  NUM_REQ  per-requester byte accepted.
- tx_valid  output  1  byte offered to uart_tx.
- tx_data  output  DATA_WIDTH  byte to uart_tx.
- tx_ready  input  1  uart_tx can accept a byte.
- busy  output  1  a grant is held.
- grant_id  output  2  index of the current grantee; 0 when not busy.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, rr_ptr=0, burst_cnt=0.
  - req_ready=0, tx_valid=0, tx_data=0, busy=0, grant_id=0.
  - Reset overrides any in-flight handshake in the same cycle; no byte is counted as transferred.
- States: IDLE and GRANT.
- IDLE:
  - All req_ready=0 and tx_valid=0.
  - If any req_valid is set, pick the first set index searching circularly from rr_ptr.
  - Register it as grant, clear burst_cnt and go to GRANT. Arbitration latency is 1 cycle.
  - With no request, stay in IDLE.
- GRANT (g = grant):
  - Pass-through is combinational: tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready.
  - req_ready of every other requester is 0. tx_data=0 when tx_valid=0.
  - busy=1 and grant_id=g.
  - A transfer is req_valid[g] && tx_ready in the same cycle. Each transfer increments burst_cnt (8-bit).
- Release occurs on a transfer where req_last[g]==1, or where burst_cnt+1==MAX_BURST. On release:
  - rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
  - The releasing byte is still delivered that cycle.
- If both release conditions hit on the same byte, there is a single release; no double-advance of rr_ptr.
- If req_valid[g] drops mid-message, the grant is held indefinitely. Other requesters wait; there is no timeout.
- Requesters asserting valid while not granted must hold data stable; the arbiter never drops or duplicates a byte.
- The minimum gap between grants is one IDLE cycle, so back-to-back messages from different requesters see exactly 1 bubble cycle.
- grant_id width is 2 regardless of NUM_REQ; unused upper values never appear.

Decomposition:
- Shared header: state encodings (ST_IDLE=0, ST_GRANT=1) and the constant GRANT_ID_W=2.
- One sub-module, rr_pick:
  - Combinational circular priority encoder.
  - Inputs: req[NUM_REQ] and ptr.
  - Outputs: any and idx.
  - Instanced once in IDLE-state logic.
- The top-level tile instantiates uart_tx_arbiter in front of uart_tx.

Test Plan:
- Reset hold: reset=0 for 3 cycles with all req_valid=1 -> req_ready=0, tx_valid=0, busy=0, grant_id=0 throughout.
- Single message: req0 sends 0x41, 0x42, 0x43 (last on 0x43), tx_ready=1 -> grant_id=0 from cycle 1; tx_data sequence 41, 42, 43; busy drops the cycle after 0x43.
- Round robin: both requesters valid continuously, 2-byte messages (A0, A1 and B0, B1) -> tx order A0 A1 B0 B1 A0 A1...; 1 idle bubble between messages; req_ready[1]=0 during grant 0.
- Backpressure: tx_ready toggles 1, 0, 0, 1 during a req1 message 0x10, 0x11 -> each byte is delivered exactly once; req_ready[1] mirrors tx_ready; no grant change.
- Forced rotation: MAX_BURST=4, req0 streams 0x00..0x09 with no last while req1 waits -> after 4 transfers (0x00..0x03) grant moves to req1; req0 resumes with 0x04 afterwards.
- Reset mid-message: assert reset after 2 of 5 bytes -> outputs return to reset values; rr_ptr=0; after reset the lowest pending index is granted first.
